// File: rtl/debounce_scan.sv
// Multi-channel switch debouncer: one prescaler and one stable-count datapath
// time-shared across N_SW channels. Optional input sync: DEBOUNCE_SCAN_SYNC_EN.
module debounce_scan #(
  parameter int N_SW         = 4,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 8
) (
  input  logic            clk50m,
  input  logic            rst,
  input  logic [N_SW-1:0] sw,
  output logic [N_SW-1:0] sw_dbnc,
  output logic [N_SW-1:0] sw_hi,
  output logic [N_SW-1:0] sw_lo,
  output logic            scan_busy
);
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam int DW = $clog2(TICK_DIV);
  localparam int IW = (N_SW > 1) ? $clog2(N_SW) : 1;

  generate
    if (TICK_DIV <= N_SW) begin : g_bad_cfg
      $error("debounce_scan: TICK_DIV must exceed N_SW");
    end
  endgenerate

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                   state_q, state_d;
  logic [DW-1:0]            div_q, div_d;
  logic                     tick;
  logic [IW-1:0]            idx_q, idx_d;
  logic [N_SW-1:0][CW-1:0]  cnt_q, cnt_d;
  logic [N_SW-1:0]          dbnc_q, dbnc_d;
  logic [N_SW-1:0]          hi_q, hi_d;
  logic [N_SW-1:0]          lo_q, lo_d;
  logic [N_SW-1:0]          samp;
  logic                     s;

`ifdef DEBOUNCE_SCAN_SYNC_EN
  logic [N_SW-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk50m) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
    end
  end

  assign samp = sync2_q;
`else
  assign samp = sw;
`endif

  always_comb begin
    tick  = (div_q == DW'(TICK_DIV - 1));
    div_d = tick ? '0 : div_q + 1'b1;
  end

  // Only the channel under idx_q may change; edge pulses default to 0 every cycle.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    dbnc_d    = dbnc_q;
    hi_d      = '0;
    lo_d      = '0;
    scan_busy = 1'b0;
    s         = samp[idx_q];
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        scan_busy = 1'b1;
        if (s == dbnc_q[idx_q]) begin
          cnt_d[idx_q] = '0;
        end else if (cnt_q[idx_q] == CW'(STABLE_TICKS - 1)) begin
          dbnc_d[idx_q] = s;
          cnt_d[idx_q]  = '0;
          hi_d[idx_q]   = s;
          lo_d[idx_q]   = ~s;
        end else begin
          cnt_d[idx_q] = cnt_q[idx_q] + 1'b1;
        end
        if (idx_q == IW'(N_SW - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk50m) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      dbnc_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dbnc_q  <= dbnc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign sw_dbnc = dbnc_q;
  assign sw_hi   = hi_q;
  assign sw_lo   = lo_q;
endmodule

// File: tb/tb_debounce_scan.sv
// Bench for debounce_scan: cycle-indexed reference model, directed scenarios then
// randomized switch patterns; inputs only change mid-idle so sync latency is hidden.
`define DEBOUNCE_SCAN_SYNC_EN
module tb_debounce_scan;
  localparam int N  = 4;
  localparam int TD = 10;
  localparam int ST = 3;

  logic         clk50m = 1'b0;
  logic         rst    = 1'b1;
  logic [N-1:0] sw     = '0;
  logic [N-1:0] sw_dbnc, sw_hi, sw_lo;
  logic         scan_busy;

  debounce_scan #(.N_SW(N), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
    .clk50m(clk50m), .rst(rst), .sw(sw),
    .sw_dbnc(sw_dbnc), .sw_hi(sw_hi), .sw_lo(sw_lo), .scan_busy(scan_busy)
  );

  always #5 clk50m = ~clk50m;

  int errs = 0, checks = 0;
  int n = 0;            // cycle index since reset released; prescaler phase is n % TD
  int mcnt [N];
  logic [N-1:0] m_dbnc = '0, m_hi = '0, m_lo = '0;
  int hi0_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (n=%0d)", tag, got, exp, n);
    end
  endtask

  // Cycle n scans channel n%TD when n%TD < N, from the second period on.
  task automatic model_edge();
    if (rst) begin
      n = 0; m_dbnc = '0; m_hi = '0; m_lo = '0;
      for (int k = 0; k < N; k++) mcnt[k] = 0;
    end else begin
      m_hi = '0; m_lo = '0;
      if (n >= TD && (n % TD) < N) begin
        int k;
        k = n % TD;
        if (sw[k] == m_dbnc[k]) mcnt[k] = 0;
        else if (mcnt[k] + 1 < ST) mcnt[k]++;
        else begin
          m_dbnc[k] = sw[k]; mcnt[k] = 0;
          m_hi[k] = sw[k]; m_lo[k] = ~sw[k];
        end
      end
      n++;
    end
  endtask

  task automatic step();
    logic busy;
    @(posedge clk50m);
    model_edge();
    #1;
    busy = (n >= TD) && ((n % TD) < N);
    chk("busy", scan_busy, busy);
    chk("dbnc", sw_dbnc, m_dbnc);
    chk("hi", sw_hi, m_hi);
    chk("lo", sw_lo, m_lo);
    if (sw_hi[0]) hi0_cnt++;
  endtask

  task automatic to_phase(input int p);
    step();
    while ((n % TD) != p) step();
  endtask

  initial begin
    for (int k = 0; k < N; k++) mcnt[k] = 0;
    rst = 1'b1; sw = '0;
    step(); step();
    rst = 1'b0;
    repeat (200) step();

    // rise on ch0
    to_phase(5); sw[0] = 1'b1; hi0_cnt = 0;
    repeat (5) to_phase(5);
    chk("rise_hi0_pulses", hi0_cnt, 1);
    chk("rise_dbnc", sw_dbnc, 4'b0001);

    // bounce on ch1
    sw[1] = 1'b1; to_phase(5); to_phase(5);
    sw[1] = 1'b0; chk("bounce_hold", sw_dbnc[1], 1'b0);
    to_phase(5); sw[1] = 1'b1;
    to_phase(5); to_phase(5); chk("bounce_wait", sw_dbnc[1], 1'b0);
    to_phase(5); chk("bounce_acc", sw_dbnc[1], 1'b1);

    // simultaneous ch2/ch3
    sw[3:2] = 2'b11; to_phase(5); to_phase(5);
    while ((n % TD) != 3) step();
    chk("sim_hi2", sw_hi, 4'b0100);
    step();
    chk("sim_hi3", sw_hi, 4'b1000);

    // release ch0
    to_phase(5); sw[0] = 1'b0;
    repeat (3) to_phase(5);
    chk("rel_dbnc0", sw_dbnc[0], 1'b0);

    // reset mid-scan with ch2 two samples into a release
    sw[2] = 1'b0; to_phase(5); to_phase(5);
    while ((n % TD) != 2) step();
    chk("mid_busy", scan_busy, 1'b1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_busy", scan_busy, 1'b0);
    chk("rst_dbnc", sw_dbnc, 4'b0000);
    to_phase(5); to_phase(5); to_phase(5);
    chk("rst_reacq_wait", sw_dbnc, 4'b0000);
    to_phase(5);
    chk("rst_reacq", sw_dbnc, 4'b1010);

    // randomized patterns with occasional reset
    repeat (80) begin
      to_phase(5);
      if ($urandom_range(0, 2) == 0) sw = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1; step(); rst = 1'b0;
      end
    end
    repeat (40) step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
